uart_frame_scheduler: RTL and testbench

- Sequences the byte-level UART transmitter for accelerometer streaming.
- Accepts one 3-axis sample (X, Y, Z, 16 bits each) from FIFO management over a valid/ready handshake.
- Serialises the sample as an 8-byte frame: sync, X hi, X lo, Y hi, Y lo, Z hi, Z lo, checksum.
- Issues one start pulse per byte, waits for each completion pulse, and counts samples it has to drop while busy.

---
 rtl/uart_frame_scheduler.sv | 157 +++++++++++++++
 tb/tb_uart_frame_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler
// Takes one 3-axis accelerometer sample over a valid/ready handshake and
// sends it to a byte-level UART transmitter as an 8-byte frame:
//   sync, X hi, X lo, Y hi, Y lo, Z hi, Z lo, checksum.
// The checksum is the mod-256 sum of the six data bytes. A fixed idle gap
// follows every frame. Samples offered while the scheduler is busy are
// counted in a saturating drop counter.
module uart_frame_scheduler #(
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int unsigned FRAME_GAP = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        sample_valid,
   input  logic [15:0] sample_x,
   input  logic [15:0] sample_y,
   input  logic [15:0] sample_z,
   output logic        sample_ready,
   output logic [7:0]  tx_byte,
   output logic        tx_start,
   input  logic        tx_done,
   output logic        frame_done,
   output logic [7:0]  drop_count
);

   localparam int unsigned GAP_W = (FRAME_GAP < 1) ? 1 : $clog2(FRAME_GAP + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t           r_state;
   logic [2:0]       r_idx;
   logic [7:0]       r_csum;
   logic [15:0]      r_x;
   logic [15:0]      r_y;
   logic [15:0]      r_z;
   logic [GAP_W-1:0] r_gap;
   logic [7:0]       r_tx_byte;
   logic             r_tx_start;
   logic             r_frame_done;
   logic [7:0]       r_drop;

   logic             w_ready;
   logic             w_accept;
   logic             w_drop_evt;
   logic             w_last;
   logic [2:0]       w_next_idx;
   logic [7:0]       w_next_byte;

   // Ready is the only combinational output; held low while reset is asserted.
   assign w_ready      = (r_state == IDLE) && enable && !rst;
   assign w_accept     = sample_valid && w_ready;
   assign w_drop_evt   = sample_valid && !w_ready && enable;
   assign w_last       = (r_idx == 3'd7);

   assign sample_ready = w_ready;
   assign tx_byte      = r_tx_byte;
   assign tx_start     = r_tx_start;
   assign frame_done   = r_frame_done;
   assign drop_count   = r_drop;

   // Select the byte for the index that follows the one currently in flight.
   always_comb begin
      w_next_idx  = r_idx + 3'd1;
      w_next_byte = SYNC_BYTE;
      case (w_next_idx)
         3'd1:    w_next_byte = r_x[15:8];
         3'd2:    w_next_byte = r_x[7:0];
         3'd3:    w_next_byte = r_y[15:8];
         3'd4:    w_next_byte = r_y[7:0];
         3'd5:    w_next_byte = r_z[15:8];
         3'd6:    w_next_byte = r_z[7:0];
         3'd7:    w_next_byte = r_csum;
         default: w_next_byte = SYNC_BYTE;
      endcase
   end

   // Frame sequencer. tx_start/tx_byte are loaded on the transition into SEND
   // so the pulse is visible during the single SEND cycle; the checksum is
   // accumulated at that same transition for data indices 1..6.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_csum       <= '0;
         r_x          <= '0;
         r_y          <= '0;
         r_z          <= '0;
         r_gap        <= '0;
         r_tx_byte    <= '0;
         r_tx_start   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_tx_start   <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_x        <= sample_x;
                  r_y        <= sample_y;
                  r_z        <= sample_z;
                  r_csum     <= '0;
                  r_idx      <= '0;
                  r_tx_byte  <= SYNC_BYTE;
                  r_tx_start <= 1'b1;
                  r_state    <= SEND;
               end
            end
            SEND: begin
               r_state <= WAIT;
            end
            WAIT: begin
               if (tx_done) begin
                  if (w_last) begin
                     r_frame_done <= 1'b1;
                     r_gap        <= GAP_W'(FRAME_GAP);
                     r_state      <= GAP;
                  end else begin
                     r_idx      <= w_next_idx;
                     r_tx_byte  <= w_next_byte;
                     r_tx_start <= 1'b1;
                     if (w_next_idx != 3'd7) begin
                        r_csum <= r_csum + w_next_byte;
                     end
                     r_state    <= SEND;
                  end
               end
            end
            GAP: begin
               if (r_gap == '0) begin
                  r_state <= IDLE;
               end else begin
                  r_gap <= r_gap - GAP_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Saturating count of samples offered while enabled but not ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drop <= '0;
      end else if (w_drop_evt && (r_drop != 8'hFF)) begin
         r_drop <= r_drop + 8'd1;
      end
   end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Testbench for uart_frame_scheduler: randomized samples, a UART responder,
// a reference model that predicts frames, timing and drops, and a scoreboard
// monitor that pops expected bytes on every tx_start.
module tb_uart_frame_scheduler;

   localparam int unsigned FRAME_GAP = 16;
   localparam logic [7:0]  SYNC      = 8'hA5;
   localparam longint      NEVER     = 64'h3FFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        sample_valid = 1'b0;
   logic [15:0] sx = '0;
   logic [15:0] sy = '0;
   logic [15:0] sz = '0;
   logic        sample_ready;
   logic [7:0]  tx_byte;
   logic        tx_start;
   logic        tx_done;
   logic        frame_done;
   logic [7:0]  drop_count;
   logic        uart_done = 1'b0;
   logic        spur_done = 1'b0;

   assign tx_done = uart_done | spur_done;

   always #5 clk = ~clk;

   uart_frame_scheduler #(.SYNC_BYTE(SYNC), .FRAME_GAP(FRAME_GAP)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .sample_valid (sample_valid),
      .sample_x     (sx),
      .sample_y     (sy),
      .sample_z     (sz),
      .sample_ready (sample_ready),
      .tx_byte      (tx_byte),
      .tx_start     (tx_start),
      .tx_done      (tx_done),
      .frame_done   (frame_done),
      .drop_count   (drop_count)
   );

   int checks = 0;
   int errors = 0;
   longint cyc = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state
   logic [7:0] exp_q[$];
   longint     exp_start = -1;
   longint     exp_fd    = -1;
   longint     free_at   = 0;
   bit         awaiting  = 1'b0;
   int         started   = 0;
   int         drop_m    = 0;
   int         acc_count = 0;
   int         fd_count  = 0;

   // Monitor bookkeeping
   logic [7:0] act_log[$];
   longint     last_fd    = -1;
   bit         b2b_mode   = 1'b0;
   int         mon_starts = 0;

   // Reference model: a frame is 8 bytes, each started the cycle after the
   // previous completion; the scheduler is free FRAME_GAP+1 cycles after
   // frame_done; drops counted per busy cycle while enabled.
   always @(negedge clk) begin : model_blk
      bit exp_ready;
      logic [7:0] cs;
      if (rst) begin
         check("rst_tx_start", tx_start, 0);
         check("rst_frame_done", frame_done, 0);
         check("rst_drop_count", drop_count, 0);
         check("rst_sample_ready", sample_ready, 0);
         exp_q.delete();
         exp_start = -1;
         exp_fd    = -1;
         free_at   = 0;
         awaiting  = 1'b0;
         started   = 0;
         drop_m    = 0;
      end else begin
         exp_ready = enable && (cyc >= free_at);
         check("sample_ready", sample_ready, exp_ready);
         check("tx_start_timing", tx_start, cyc == exp_start);
         check("frame_done", frame_done, cyc == exp_fd);
         check("drop_count", drop_count, drop_m);
         if (tx_done && awaiting) begin
            awaiting = 1'b0;
            if (started < 8) begin
               exp_start = cyc + 1;
            end else begin
               exp_fd  = cyc + 1;
               free_at = cyc + FRAME_GAP + 2;
               fd_count++;
            end
         end
         if (cyc == exp_start) begin
            awaiting = 1'b1;
            started++;
         end
         if (sample_valid && exp_ready) begin
            cs = sx[15:8] + sx[7:0] + sy[15:8] + sy[7:0] + sz[15:8] + sz[7:0];
            exp_q.push_back(SYNC);
            exp_q.push_back(sx[15:8]);
            exp_q.push_back(sx[7:0]);
            exp_q.push_back(sy[15:8]);
            exp_q.push_back(sy[7:0]);
            exp_q.push_back(sz[15:8]);
            exp_q.push_back(sz[7:0]);
            exp_q.push_back(cs);
            started   = 0;
            exp_start = cyc + 1;
            free_at   = NEVER;
            acc_count++;
         end
         if (sample_valid && enable && !exp_ready && drop_m < 255) drop_m++;
      end
   end

   // Scoreboard monitor: every tx_start pops one expected byte.
   always @(negedge clk) begin
      if (!rst) begin
         if (tx_start) begin
            act_log.push_back(tx_byte);
            mon_starts++;
            if (exp_q.size() == 0) check("unexpected_tx_start", tx_start, 0);
            else check("tx_byte", tx_byte, exp_q.pop_front());
         end
         if (frame_done) last_fd = cyc;
         if (b2b_mode && sample_valid && sample_ready && last_fd >= 0)
            check("b2b_gap", cyc - last_fd, FRAME_GAP + 1);
      end
   end

   // UART responder: completion pulse 10 cycles after each tx_start.
   initial begin
      forever begin
         @(negedge clk);
         if (tx_start && !rst) begin
            repeat (10) @(posedge clk);
            #1 uart_done = 1'b1;
            @(posedge clk);
            #1 uart_done = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_accept();
      int a0;
      int g;
      a0 = acc_count;
      g = 0;
      while (acc_count == a0 && g < 200) begin
         if (sample_valid) begin
            sx = 16'($urandom); sy = 16'($urandom); sz = 16'($urandom);
         end
         tick(1);
         g++;
      end
      check("accept_timeout", acc_count != a0, 1);
   endtask

   task automatic wait_frame(input int f_target);
      int g;
      g = 0;
      while (fd_count < f_target && g < 3000) begin
         if (sample_valid) begin
            sx = 16'($urandom); sy = 16'($urandom); sz = 16'($urandom);
         end
         tick(1);
         g++;
      end
      check("frame_timeout", fd_count >= f_target, 1);
   endtask

   initial begin : stim
      logic [7:0] req [8];
      int base;
      int g;
      req = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'hBD};

      tick(3);
      rst = 1'b0;
      tick(2);

      // Directed frame with known checksum
      enable = 1'b1;
      sx = 16'h1234; sy = 16'hABCD; sz = 16'h00FF;
      sample_valid = 1'b1;
      base = act_log.size();
      tick(1);
      check("directed_accept", acc_count, 1);
      sample_valid = 1'b0;
      wait_frame(fd_count + 1);
      tick(FRAME_GAP + 5);
      check("directed_len", act_log.size() - base, 8);
      for (int i = 0; i < 8; i++)
         if (base + i < act_log.size()) check("directed_byte", act_log[base + i], req[i]);

      // Back-to-back frames with valid held and data changing every cycle
      last_fd  = -1;
      b2b_mode = 1'b1;
      sample_valid = 1'b1;
      wait_frame(fd_count + 3);
      sample_valid = 1'b0;
      b2b_mode = 1'b0;
      tick(FRAME_GAP + 5);

      // Enable drops after the third byte: frame still completes, no new frame
      sample_valid = 1'b1;
      sx = 16'($urandom); sy = 16'($urandom); sz = 16'($urandom);
      mon_starts = 0;
      wait_accept();
      g = 0;
      while (mon_starts < 3 && g < 100) begin tick(1); g++; end
      enable = 1'b0;
      wait_frame(fd_count + 1);
      tick(FRAME_GAP + 40);
      check("endrop_bytes", mon_starts, 8);
      sample_valid = 1'b0;
      tick(2);

      // Spurious completions in IDLE and in SEND
      enable = 1'b1;
      spur_done = 1'b1; tick(1); spur_done = 1'b0; tick(3);
      spur_done = 1'b1; tick(1); spur_done = 1'b0; tick(2);
      mon_starts = 0;
      sample_valid = 1'b1;
      wait_accept();
      spur_done = 1'b1;
      sample_valid = 1'b0;
      tick(1);
      spur_done = 1'b0;
      wait_frame(fd_count + 1);
      tick(FRAME_GAP + 5);
      check("spurious_bytes", mon_starts, 8);

      // Reset while waiting on byte index 4
      sample_valid = 1'b1;
      mon_starts = 0;
      wait_accept();
      g = 0;
      while (mon_starts < 5 && g < 200) begin tick(1); g++; end
      check("mid_reset_reach", mon_starts, 5);
      tick(2);
      rst = 1'b1;
      sample_valid = 1'b0;
      tick(2);
      rst = 1'b0;
      enable = 1'b0;
      tick(20);
      enable = 1'b1;
      base = act_log.size();
      sample_valid = 1'b1;
      wait_accept();
      sample_valid = 1'b0;
      wait_frame(fd_count + 1);
      tick(FRAME_GAP + 5);
      check("post_reset_len", act_log.size() - base, 8);
      if (act_log.size() > base) check("post_reset_sync", act_log[base], SYNC);

      // Drop counter saturation
      sample_valid = 1'b1;
      g = 0;
      while (drop_m < 255 && g < 1500) begin
         sx = 16'($urandom); sy = 16'($urandom); sz = 16'($urandom);
         tick(1);
         g++;
      end
      tick(40);
      check("drop_saturated", drop_count, 8'hFF);
      sample_valid = 1'b0;
      g = 0;
      while (free_at == NEVER && g < 500) begin tick(1); g++; end
      tick(FRAME_GAP + 10);
      check("queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
